// File: rtl/pixel_pool_downscaler_pkg.sv
// pixel_pool_downscaler_pkg: pooling mode encodings and shared combine arithmetic
package pixel_pool_downscaler_pkg;
  typedef enum logic [1:0] {
    POOL_AVG   = 2'd0,
    POOL_MAX   = 2'd1,
    POOL_MIN   = 2'd2,
    POOL_DECIM = 2'd3
  } pool_mode_e;
  localparam int POOL_ACC_W = 32;
  function automatic logic [POOL_ACC_W-1:0] pool_combine(pool_mode_e mode, logic [POOL_ACC_W-1:0] acc,
                                                         logic [POOL_ACC_W-1:0] val, logic first);
    return first ? val :
           mode == POOL_AVG ? acc + val :
           mode == POOL_MAX ? (val > acc ? val : acc) :
           mode == POOL_MIN ? (val < acc ? val : acc) : acc;
  endfunction
  function automatic logic [POOL_ACC_W-1:0] pool_result(pool_mode_e mode, logic [POOL_ACC_W-1:0] acc, int shift);
    return mode == POOL_AVG ? acc >> shift : acc;
  endfunction
endpackage

// File: rtl/pixel_pool_downscaler_sync_fifo.sv
// sync_fifo: single-clock FIFO; FIFO_TYPE 1 is first-word-fall-through, 0 registers the read data
module sync_fifo #(
  parameter int FIFO_TYPE  = 0,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic push, pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    pop = rd_en && !empty;
    push = wr_en && (!full || pop);
    rd_data = FIFO_TYPE == 1 ? mem[rd_ptr[AW-1:0]] : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) rd_q <= mem[rd_ptr[AW-1:0]];
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/pixel_pool_downscaler.sv
// pixel_pool_downscaler: SxS block pooling of a raster grayscale stream into a FIFO-buffered output
module pixel_pool_downscaler
  import pixel_pool_downscaler_pkg::*;
#(
  parameter int POOL_MODE      = 0,
  parameter int SCALE_LOG2     = 1,
  parameter int GS_PXL_W       = 8,
  parameter int COL_NUM        = 640,
  parameter int ROW_NUM        = 480,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [GS_PXL_W-1:0] dsm_pxl_i,
  input  logic                dsm_pxl_vld_i,
  input  logic                dsm_sof_i,
  input  logic                amc_aw_rdy_i,
  input  logic                amc_w_rdy_i,
  output logic                dsm_pxl_rdy_o,
  output logic [GS_PXL_W-1:0] ds_pxl_o,
  output logic                ds_pxl_vld_o,
  output logic                ds_last_o
);
  localparam int S = 1 << SCALE_LOG2;
  localparam int ACC_W = GS_PXL_W + 2 * SCALE_LOG2;
  localparam int BLK_COLS = COL_NUM / S;
  localparam int BLK_ROWS = ROW_NUM / S;
  localparam int CW = $clog2(COL_NUM);
  localparam int RW = BLK_ROWS > 1 ? $clog2(BLK_ROWS) : 1;
  localparam int BW = CW - SCALE_LOG2;
  localparam pool_mode_e MODE = pool_mode_e'(POOL_MODE[1:0]);
  logic [CW-1:0] col_cnt, col;
  logic [SCALE_LOG2-1:0] sub_row, srow;
  logic [RW-1:0] blk_row, brow;
  logic [BW-1:0] blk_col;
  logic [ACC_W-1:0] partial, part_nxt, lb_nxt;
  logic [ACC_W-1:0] line_buf [BLK_COLS];
  logic [GS_PXL_W:0] fifo_din, fifo_dout;
  logic hs, pop, full, empty, h_last, blk_done, frame_last, col_wrap;
  // A start-of-frame pixel is placed at (0,0) regardless of the counters, so stale partials never merge.
  always_comb begin
    col = dsm_sof_i ? '0 : col_cnt;
    srow = dsm_sof_i ? '0 : sub_row;
    brow = dsm_sof_i ? '0 : blk_row;
    blk_col = col[CW-1:SCALE_LOG2];
    col_wrap = col == CW'(COL_NUM - 1);
    h_last = &col[SCALE_LOG2-1:0];
    blk_done = h_last && &srow;
    frame_last = blk_done && col_wrap && brow == RW'(BLK_ROWS - 1);
    part_nxt = ACC_W'(pool_combine(MODE, 32'(partial), 32'(dsm_pxl_i), col[SCALE_LOG2-1:0] == '0));
    lb_nxt = ACC_W'(pool_combine(MODE, 32'(line_buf[blk_col]), 32'(part_nxt), srow == '0));
    fifo_din = {frame_last, GS_PXL_W'(pool_result(MODE, 32'(lb_nxt), 2 * SCALE_LOG2))};
    ds_pxl_vld_o = !empty;
    ds_pxl_o = ds_pxl_vld_o ? fifo_dout[GS_PXL_W-1:0] : '0;
    ds_last_o = ds_pxl_vld_o && fifo_dout[GS_PXL_W];
    pop = ds_pxl_vld_o && amc_aw_rdy_i && amc_w_rdy_i;
    dsm_pxl_rdy_o = !(blk_done && full) || pop;
    hs = dsm_pxl_vld_i && dsm_pxl_rdy_o;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt <= '0;
      sub_row <= '0;
      blk_row <= '0;
      partial <= '0;
    end else if (hs) begin
      partial <= part_nxt;
      col_cnt <= col_wrap ? '0 : col + 1'b1;
      sub_row <= col_wrap ? srow + 1'b1 : srow;
      blk_row <= !(col_wrap && &srow) ? brow : brow == RW'(BLK_ROWS - 1) ? '0 : brow + 1'b1;
    end
  always_ff @(posedge clk)
    if (hs && h_last) line_buf[blk_col] <= lb_nxt;
  sync_fifo #(
    .FIFO_TYPE (1),
    .DATA_WIDTH(GS_PXL_W + 1),
    .DEPTH     (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (hs && blk_done),
    .wr_data(fifo_din),
    .rd_en  (pop),
    .rd_data(fifo_dout),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: doc/pixel_pool_downscaler.md
PIXEL_POOL_DOWNSCALER -- requirements
Module: pixel_pool_downscaler

Interface
REQ-001 SHALL have parameter POOL_MODE, default 0: 0 average, 1 max, 2 min, 3 decimate (top-left pixel).
REQ-002 SHALL have parameter SCALE_LOG2, default 1: block size S = 2^SCALE_LOG2 (legal 1..3).
REQ-003 SHALL have parameter GS_PXL_W, default 8: grayscale pixel width.
REQ-004 SHALL have parameters COL_NUM, default 640, and ROW_NUM, default 480: frame size; both are multiples of S.
REQ-005 SHALL have parameter OUT_FIFO_DEPTH, default 4: output FIFO entries (power of 2, >=2).
REQ-006 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-007 SHALL have ports dsm_pxl_i (in, GS_PXL_W, input pixel), dsm_pxl_vld_i (in, 1, input valid) and dsm_sof_i (in, 1, marks the frame's first pixel).
REQ-008 SHALL have ports amc_aw_rdy_i and amc_w_rdy_i (in, 1 each, AXI master ready inputs).
REQ-009 SHALL have ports dsm_pxl_rdy_o (out, 1, input ready), ds_pxl_o (out, GS_PXL_W, pooled pixel), ds_pxl_vld_o (out, 1, output valid) and ds_last_o (out, 1, last pooled pixel of frame).

Function
REQ-010 SHALL accept an input pixel only on dsm_pxl_vld_i & dsm_pxl_rdy_o (input handshake).
REQ-011 SHALL keep col_cnt (0..COL_NUM-1), sub_row (0..S-1) and blk_row (0..ROW_NUM/S-1); col_cnt advances per input handshake; a wrap advances sub_row; a sub_row wrap advances blk_row; all wrap to 0 after the frame's last pixel.
REQ-012 SHALL treat an input handshake with dsm_sof_i=1 as position (0,0), discarding partial accumulations.
REQ-013 SHALL fold each pixel into a horizontal partial; at col_cnt mod S = S-1 it SHALL merge the partial into line-buffer entry col_cnt/S (COL_NUM/S entries), overwriting that entry when sub_row=0.
REQ-014 average accumulators SHALL be GS_PXL_W+2*SCALE_LOG2 bits wide, without overflow; output = sum >> 2*SCALE_LOG2, truncated.
REQ-015 max/min SHALL use unsigned compare; decimate SHALL keep the pixel at block offset (0,0).
REQ-016 completing a block (sub_row=S-1, col_cnt mod S=S-1) SHALL push the pooled value into the output FIFO.
REQ-017 dsm_pxl_rdy_o SHALL be 0 only when the next pixel completes a block and the output FIFO is full; otherwise 1.
REQ-018 ds_pxl_vld_o SHALL equal output FIFO not-empty and SHALL NOT depend on AMC readies.
REQ-019 output handshake SHALL be ds_pxl_vld_o & amc_aw_rdy_i & amc_w_rdy_i; each handshake pops one entry.
REQ-020 with the FIFO empty, ds_pxl_vld_o SHALL rise the cycle after the block-completing input handshake (latency 1).
REQ-021 simultaneous push and pop on a full FIFO SHALL be allowed; the input stall is released in the same cycle.
REQ-022 ds_last_o SHALL travel in the FIFO with the pooled pixel of the final block (blk_row and col_cnt at maximum); it is valid only with ds_pxl_vld_o.
REQ-023 ds_pxl_o and ds_last_o SHALL hold stable while ds_pxl_vld_o=1 and no output handshake occurs.

Reset
REQ-024 SHALL clear all counters, the partial register and FIFO pointers on rst_n low; line-buffer contents need no reset.
REQ-025 during reset SHALL drive ds_pxl_vld_o=0, ds_last_o=0, ds_pxl_o=0, dsm_pxl_rdy_o=1.
REQ-026 reset mid-frame SHALL drop all buffered and partial data; the next accepted pixel is position (0,0).

Structure
REQ-027 a shared package SHALL hold POOL_MODE encodings (AVG, MAX, MIN, DECIM) and a pool-combine function for width/mode arithmetic.
REQ-028 the output FIFO SHALL be the codebase sync_fifo (FIFO_TYPE 1, DATA_WIDTH GS_PXL_W+1); it is the only sub-module.

Verification
REQ-029 4x4 frame, S=2, AVG, pixels 0..15 row-major, AMC ready -> outputs 2,4,10,12; ds_last_o only on 12.
REQ-030 same stimulus, MAX -> 5,7,13,15; MIN -> 0,2,8,10; DECIM -> 0,2,8,10.
REQ-031 S=2, 8-bit, all pixels 255, AVG -> every output 255 (no overflow).
REQ-032 OUT_FIFO_DEPTH=2, amc_w_rdy_i=0, 4x4 frame -> after 2 outputs dsm_pxl_rdy_o=0 at the third block's completing pixel; readies=1 releases the stall and all 4 outputs arrive in order.
REQ-033 dsm_sof_i pulsed at pixel 6 of a frame -> prior partials discarded; the next 16 pixels yield 4 correct outputs.
REQ-034 rst_n low mid-frame with 1 FIFO entry pending -> ds_pxl_vld_o=0 at once; a new full frame yields exactly 4 outputs.
